// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN classifier: phase codes, sizes, layer-three weights, FSM states.
package bnn_pkg;

  localparam logic [2:0] S_LAYER_2 = 3'b011;
  localparam logic [2:0] S_LAYER_3 = 3'b100;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned FEAT_BITS   = 196;

  // Deterministic weight image, class-major; each row is built by its own short loop.
  function automatic logic [NUM_CLASSES*FEAT_BITS-1:0] gen_weights3();
    logic [31:0] s;
    logic [NUM_CLASSES*FEAT_BITS-1:0] w;
    s = 32'h1F2E_3D4C;
    w = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      for (int unsigned i = 0; i < FEAT_BITS; i++) begin
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        w[c*FEAT_BITS + i] = s[31];
      end
    end
    return w;
  endfunction

  localparam logic [NUM_CLASSES*FEAT_BITS-1:0] WEIGHTS3 = gen_weights3();

  typedef enum logic [1:0] {
    L3_IDLE,
    L3_ACCUM,
    L3_COMPARE,
    L3_DONE
  } l3_state_e;

endpackage

// File: rtl/xnor_popcount.sv
// Combinational count of matching bit positions between a and b.
module xnor_popcount #(
  parameter int unsigned W  = 28,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count = count + CW'(a[i] == b[i]);
    end
  end

endmodule

// File: rtl/layer_three.sv
// Layer-three binary classifier: chunked xnor-popcount scoring per class, argmax with low-index ties.
// Optional score outputs are enabled by defining LAYER3_SCORE_OUT_EN.
module layer_three
  import bnn_pkg::*;
#(
  parameter int unsigned CHUNK_W = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           state,
  input  logic [FEAT_BITS-1:0] feature,
  output logic [3:0]           class_out,
  output logic                 done
`ifdef LAYER3_SCORE_OUT_EN
  ,
  output logic [7:0]           best_score,
  output logic [79:0]          scores
`endif
);

  localparam int unsigned NUM_CHUNKS = FEAT_BITS / CHUNK_W;
  localparam int unsigned CNT_W      = $clog2(CHUNK_W + 1);
  localparam logic [5:0]  LAST_CHUNK = 6'(NUM_CHUNKS - 1);
  localparam logic [3:0]  LAST_CLASS = 4'(NUM_CLASSES - 1);

  l3_state_e              fsm_q, fsm_d;
  logic                   go;
  logic [FEAT_BITS-1:0]   feat_q, feat_d;
  logic [3:0]             cls_q, cls_d;
  logic [5:0]             chunk_q, chunk_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             best_score_q, best_score_d;
  logic [3:0]             best_class_q, best_class_d;
  logic                   done_q, done_d;
  logic [3:0]             class_out_q, class_out_d;
`ifdef LAYER3_SCORE_OUT_EN
  logic [79:0]            scores_q, scores_d;
`endif

  logic [7:0]             f_base;
  logic [10:0]            w_base;
  logic [CHUNK_W-1:0]     feat_chunk;
  logic [CHUNK_W-1:0]     wt_chunk;
  logic [CNT_W-1:0]       chunk_pop;

  assign go = (state == S_LAYER_3);

  always_comb begin
    f_base     = 8'(chunk_q) * 8'(CHUNK_W);
    w_base     = 11'(cls_q) * 11'(FEAT_BITS) + 11'(f_base);
    feat_chunk = feat_q[f_base +: CHUNK_W];
    wt_chunk   = WEIGHTS3[w_base +: CHUNK_W];
  end

  xnor_popcount #(
    .W (CHUNK_W),
    .CW(CNT_W)
  ) u_pop (
    .a    (feat_chunk),
    .b    (wt_chunk),
    .count(chunk_pop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= L3_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      L3_IDLE:    if (go) fsm_d = L3_ACCUM;
      L3_ACCUM:   if (go && chunk_q == LAST_CHUNK) fsm_d = L3_COMPARE;
      L3_COMPARE: if (go) fsm_d = (cls_q == LAST_CLASS) ? L3_DONE : L3_ACCUM;
      L3_DONE:    fsm_d = L3_DONE;
      default:    fsm_d = L3_IDLE;
    endcase
  end

  // Datapath next-state; class_out takes the post-compare winner so the last class counts.
  always_comb begin
    feat_d       = feat_q;
    cls_d        = cls_q;
    chunk_d      = chunk_q;
    acc_d        = acc_q;
    best_score_d = best_score_q;
    best_class_d = best_class_q;
    done_d       = done_q;
    class_out_d  = class_out_q;
`ifdef LAYER3_SCORE_OUT_EN
    scores_d     = scores_q;
`endif
    unique case (fsm_q)
      L3_IDLE: begin
        if (go) begin
          feat_d  = feature;
          cls_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
        end
      end
      L3_ACCUM: begin
        if (go) begin
          acc_d   = acc_q + 8'(chunk_pop);
          chunk_d = (chunk_q == LAST_CHUNK) ? '0 : chunk_q + 6'd1;
        end
      end
      L3_COMPARE: begin
        if (go) begin
          if (cls_q == '0 || acc_q > best_score_q) begin
            best_score_d = acc_q;
            best_class_d = cls_q;
          end
`ifdef LAYER3_SCORE_OUT_EN
          scores_d[{cls_q, 3'b000} +: 8] = acc_q;
`endif
          acc_d = '0;
          if (cls_q == LAST_CLASS) begin
            done_d      = 1'b1;
            class_out_d = best_class_d;
          end else begin
            cls_d = cls_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      feat_q       <= '0;
      cls_q        <= '0;
      chunk_q      <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
      done_q       <= 1'b0;
      class_out_q  <= '0;
`ifdef LAYER3_SCORE_OUT_EN
      scores_q     <= '0;
`endif
    end else begin
      feat_q       <= feat_d;
      cls_q        <= cls_d;
      chunk_q      <= chunk_d;
      acc_q        <= acc_d;
      best_score_q <= best_score_d;
      best_class_q <= best_class_d;
      done_q       <= done_d;
      class_out_q  <= class_out_d;
`ifdef LAYER3_SCORE_OUT_EN
      scores_q     <= scores_d;
`endif
    end
  end

  assign class_out = class_out_q;
  assign done      = done_q;
`ifdef LAYER3_SCORE_OUT_EN
  assign best_score = best_score_q;
  assign scores     = scores_q;
`endif

endmodule

// File: tb/tb_layer_three.sv
// Self-checking bench for layer_three: table of feature vectors plus pause/snapshot/reset sequences.
module tb_layer_three;
  import bnn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           state;
  logic [FEAT_BITS-1:0] feature;
  logic [3:0]           class_out;
  logic                 done;
`ifdef LAYER3_SCORE_OUT_EN
  logic [7:0]           best_score;
  logic [79:0]          scores;
`endif

  layer_three #(.CHUNK_W(28)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .feature  (feature),
    .class_out(class_out),
    .done     (done)
`ifdef LAYER3_SCORE_OUT_EN
    ,
    .best_score(best_score),
    .scores    (scores)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  localparam int unsigned NEVER = 32'hFFFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [FEAT_BITS-1:0] row(input int unsigned c);
    return WEIGHTS3[c*FEAT_BITS +: FEAT_BITS];
  endfunction

  // Full-width reference: score every class, keep the first strict maximum.
  task automatic golden(input logic [FEAT_BITS-1:0] f, output logic [3:0] cls,
                        output logic [7:0] best, output logic [79:0] sc);
    logic [7:0] s;
    cls = '0;
    best = '0;
    sc = '0;
    for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
      s = 8'($countones(~(f ^ row(c))));
      sc[c*8 +: 8] = s;
      if (c == 0 || s > best) begin
        best = s;
        cls  = 4'(c);
      end
    end
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    state = S_LAYER_3;
    @(posedge clk);
    #1;
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_class"}, 32'(class_out), 0);
`ifdef LAYER3_SCORE_OUT_EN
    chk({name, "_best"}, 32'(best_score), 0);
    chk({name, "_scores"}, 32'(|scores), 0);
`endif
    rst_n = 1'b1;
  endtask

  // Drives one run; inputs set for edge e before it, outputs sampled 1 time unit after it.
  task automatic run(input logic [FEAT_BITS-1:0] f0, input logic [FEAT_BITS-1:0] f1,
                     input int unsigned sw_edge, input int unsigned p_lo, input int unsigned p_hi,
                     input int unsigned rst_edge, output int unsigned first);
    first = 0;
    for (int unsigned e = 1; e <= 250 && first == 0; e++) begin
      feature = (e >= sw_edge) ? f1 : f0;
      state   = (e >= p_lo && e <= p_hi) ? S_LAYER_2 : S_LAYER_3;
      rst_n   = (e == rst_edge) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (e == rst_edge) begin
        chk("midrun_rst_done", 32'(done), 0);
        chk("midrun_rst_class", 32'(class_out), 0);
      end
      if (done) first = e;
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [FEAT_BITS-1:0] feat;
    logic [3:0]           cls;
    bit                   use_gold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int unsigned first;
    logic [3:0]  g_cls;
    logic [7:0]  g_best;
    logic [79:0] g_sc;
    logic [3:0]  held;

    rst_n   = 1'b0;
    state   = 3'b000;
    feature = '0;
    do_reset("init_rst");

    vecs[0] = '{row(3), 4'd3, 1'b0};
    vecs[1] = '{row(0), 4'd0, 1'b0};
    vecs[2] = '{row(9), 4'd9, 1'b0};
    vecs[3] = '{'0, 4'd0, 1'b1};
    vecs[4] = '{'1, 4'd0, 1'b1};
    for (int unsigned k = 5; k < 8; k++) begin
      vecs[k].use_gold = 1'b1;
      vecs[k].cls      = '0;
      for (int unsigned b = 0; b < FEAT_BITS; b++) vecs[k].feat[b] = 1'($urandom_range(0, 1));
    end
    // Vector 7 stays close to row 6 so the winner is a non-trivial class.
    vecs[7].feat = row(6) ^ (vecs[7].feat & {FEAT_BITS/4{4'b0001}});

    for (int unsigned i = 0; i < 8; i++) begin
      golden(vecs[i].feat, g_cls, g_best, g_sc);
      if (vecs[i].use_gold) vecs[i].cls = g_cls;
      do_reset($sformatf("v%0d_rst", i));
      run(vecs[i].feat, vecs[i].feat, NEVER, NEVER, NEVER, NEVER, first);
      chk($sformatf("v%0d_done_edge", i), first, 81);
      chk($sformatf("v%0d_class", i), 32'(class_out), 32'(vecs[i].cls));
`ifdef LAYER3_SCORE_OUT_EN
      chk($sformatf("v%0d_best", i), 32'(best_score), 32'(g_best));
      for (int unsigned c = 0; c < NUM_CLASSES; c++)
        chk($sformatf("v%0d_score%0d", i, c), 32'(scores[c*8 +: 8]), 32'(g_sc[c*8 +: 8]));
`endif
      if (i == 0) begin
`ifdef LAYER3_SCORE_OUT_EN
        chk("row3_best196", 32'(best_score), 196);
`endif
        // Done is sticky: drop the phase, scramble the feature, then restore the phase.
        held    = class_out;
        state   = 3'b000;
        feature = ~feature;
        repeat (5) @(posedge clk);
        state = S_LAYER_3;
        repeat (5) @(posedge clk);
        #1;
        chk("sticky_done", 32'(done), 1);
        chk("sticky_class", 32'(class_out), 32'(held));
      end
    end

    do_reset("done_rst");

    // Pause for edges 20..29 delays completion by ten edges.
    do_reset("pause_rst");
    run(row(7), row(7), NEVER, 20, 29, NEVER, first);
    chk("pause_done_edge", first, 91);
    chk("pause_class", 32'(class_out), 7);

    // Feature changes after the snapshot are ignored.
    do_reset("snap_rst");
    run(row(2), row(5), 5, NEVER, NEVER, NEVER, first);
    chk("snap_done_edge", first, 81);
    chk("snap_class", 32'(class_out), 2);

    // Reset at edge 40 restarts: edge 41 begins a fresh run, done on edge 121.
    do_reset("mid_rst");
    run(row(4), row(4), NEVER, NEVER, NEVER, 40, first);
    chk("midrun_done_edge", first, 121);
    chk("midrun_class", 32'(class_out), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
